// File: rtl/lcd_hd44780_rx.sv
// lcd_hd44780_rx: responder end of a 4-bit HD44780 character-LCD bus.
//
// Samples RS/E/D[7:4] on CLK. It follows the controller's 8-bit to 4-bit init
// sequence, reassembles nibbles into bytes, and decodes the instruction subset
// the namebadge uses. It emits registered command and DDRAM-write strobes.
//
// Optional build macro: LCD_RX_TIMEOUT_EN
//   When this macro is defined, a high nibble that is not followed by a low
//   nibble within TIMEOUT_CYCLES is discarded, and sync_err is set and stays
//   set until reset.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   RS         register select (0 instruction, 1 data)
//   E          enable strobe, bus latched on its falling edge
//   din        D[7:4]
//   mode4      4-bit interface active
//   cmd_valid  one-cycle pulse, instruction received
//   cmd_byte   last instruction byte
//   wr_valid   one-cycle pulse, data byte written
//   wr_addr    DDRAM address of that write
//   wr_data    data byte of that write
//   cur_addr   current DDRAM address counter
//   disp_on    display-on bit from Display Control
//   sync_err   sticky nibble-timeout flag (0 unless LCD_RX_TIMEOUT_EN)
module lcd_hd44780_rx #(
   parameter int unsigned ADDR_W         = 7,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RS,
   input  logic              E,
   input  logic [3:0]        din,
   output logic              mode4,
   output logic              cmd_valid,
   output logic [7:0]        cmd_byte,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [ADDR_W-1:0] cur_addr,
   output logic              disp_on,
   output logic              sync_err
);

   typedef enum logic [1:0] {StMode8, StHi, StLo} state_e;

   // Input synchronizers; E gets a third stage for edge detection.
   logic       rs_s1_q, rs_s2_q;
   logic       e_s1_q, e_s2_q, e_s3_q;
   logic [3:0] din_s1_q, din_s2_q;
   logic       fe;

   state_e            state_q, state_d;
   logic [4:0]        hi_q, hi_d;          // {RS, D[7:4]} of the held high nibble
   logic              mode4_q, mode4_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [7:0]        cmd_byte_q, cmd_byte_d;
   logic              wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic              disp_on_q, disp_on_d;
   logic              id_q, id_d;          // entry mode: 1 increment, 0 decrement
   logic              sync_err_q, sync_err_d;

   logic              dec_en;
   logic              dec_rs;
   logic [7:0]        dec_byte;

   assign fe = ~e_s2_q & e_s3_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rs_s1_q  <= 1'b0;
         rs_s2_q  <= 1'b0;
         e_s1_q   <= 1'b0;
         e_s2_q   <= 1'b0;
         e_s3_q   <= 1'b0;
         din_s1_q <= 4'h0;
         din_s2_q <= 4'h0;
      end else begin
         rs_s1_q  <= RS;
         rs_s2_q  <= rs_s1_q;
         e_s1_q   <= E;
         e_s2_q   <= e_s1_q;
         e_s3_q   <= e_s2_q;
         din_s1_q <= din;
         din_s2_q <= din_s1_q;
      end
   end

`ifdef LCD_RX_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] to_cnt_q, to_cnt_d;
   logic            timeout;

   // Counts idle cycles spent waiting for a low nibble.
   always_comb begin
      to_cnt_d = '0;
      timeout  = 1'b0;
      if (state_q == StLo && !fe) begin
         if (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            timeout = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   logic timeout;
   logic unused_timeout_cfg;
   assign timeout            = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      mode4_d     = mode4_q;
      cmd_valid_d = 1'b0;
      cmd_byte_d  = cmd_byte_q;
      wr_valid_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      cur_addr_d  = cur_addr_q;
      disp_on_d   = disp_on_q;
      id_d        = id_q;
      sync_err_d  = sync_err_q;
      dec_en      = 1'b0;
      dec_rs      = rs_s2_q;
      dec_byte    = {din_s2_q, 4'h0};

      if (fe) begin
         case (state_q)
            StMode8: begin
               dec_en   = 1'b1;
               dec_rs   = rs_s2_q;
               dec_byte = {din_s2_q, 4'h0};
            end
            StHi: begin
               hi_d    = {rs_s2_q, din_s2_q};
               state_d = StLo;
            end
            StLo: begin
               // The RS captured with the high nibble qualifies the whole byte.
               dec_en   = 1'b1;
               dec_rs   = hi_q[4];
               dec_byte = {hi_q[3:0], din_s2_q};
               state_d  = StHi;
            end
            default: state_d = StMode8;
         endcase
      end else if (timeout) begin
         state_d    = StHi;
         sync_err_d = 1'b1;
      end

      if (dec_en) begin
         if (dec_rs) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = cur_addr_q;
            wr_data_d  = dec_byte;
            // Natural wrap of the ADDR_W-bit counter gives max->0 and 0->max.
            cur_addr_d = id_q ? cur_addr_q + 1'b1 : cur_addr_q - 1'b1;
         end else begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = dec_byte;
            casez (dec_byte)
               8'b1???_????: cur_addr_d = dec_byte[ADDR_W-1:0];
               8'b001?_????: begin
                  if (dec_byte[4]) begin
                     state_d = StMode8;
                     mode4_d = 1'b0;
                  end else if (state_q == StMode8) begin
                     state_d = StHi;
                     mode4_d = 1'b1;
                  end
               end
               8'b0000_1???: disp_on_d = dec_byte[2];
               8'b0000_01??: id_d = dec_byte[1];
               8'b0000_001?: cur_addr_d = '0;
               8'b0000_0001: begin
                  cur_addr_d = '0;
                  id_d       = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StMode8;
         hi_q        <= '0;
         mode4_q     <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_byte_q  <= '0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         cur_addr_q  <= '0;
         disp_on_q   <= 1'b0;
         id_q        <= 1'b1;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         mode4_q     <= mode4_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_byte_q  <= cmd_byte_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         cur_addr_q  <= cur_addr_d;
         disp_on_q   <= disp_on_d;
         id_q        <= id_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign mode4     = mode4_q;
   assign cmd_valid = cmd_valid_q;
   assign cmd_byte  = cmd_byte_q;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign cur_addr  = cur_addr_q;
   assign disp_on   = disp_on_q;
   assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Testbench for lcd_hd44780_rx: directed init/command/data/wrap/reset steps
// followed by random bytes, each checked against a byte-level behavioural model.
module tb_lcd_hd44780_rx;

   localparam int unsigned AW = 7;
   localparam int         AMOD = 1 << AW;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          RS  = 1'b0;
   logic          E   = 1'b0;
   logic [3:0]    din = 4'h0;
   logic          mode4;
   logic          cmd_valid;
   logic [7:0]    cmd_byte;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [AW-1:0] cur_addr;
   logic          disp_on;
   logic          sync_err;

   lcd_hd44780_rx #(
      .ADDR_W         (AW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RS        (RS),
      .E         (E),
      .din       (din),
      .mode4     (mode4),
      .cmd_valid (cmd_valid),
      .cmd_byte  (cmd_byte),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cur_addr  (cur_addr),
      .disp_on   (disp_on),
      .sync_err  (sync_err)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // Behavioural model state.
   int m_mode4, m_have_hi, m_hi_rs, m_hi_d;
   int m_addr, m_id, m_disp, m_sync, m_cmd;
   // Expected event for the nibble just sent: 0 none, 1 command, 2 write.
   int e_ev, e_byte, e_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode4 = 0; m_have_hi = 0; m_hi_rs = 0; m_hi_d = 0;
      m_addr = 0; m_id = 1; m_disp = 0; m_sync = 0; m_cmd = 0;
   endtask

   task automatic model_decode(input int rs, input int b);
      if (rs != 0) begin
         e_ev = 2; e_byte = b; e_addr = m_addr;
         m_addr = (m_id != 0) ? (m_addr + 1) % AMOD : (m_addr + AMOD - 1) % AMOD;
      end else begin
         e_ev = 1; e_byte = b; m_cmd = b;
         if (b >= 128) m_addr = b % AMOD;
         else if (b >= 32 && b < 64) m_mode4 = ((b / 16) % 2 == 1) ? 0 : 1;
         else if (b >= 8 && b < 16) m_disp = (b / 4) % 2;
         else if (b >= 4 && b < 8) m_id = (b / 2) % 2;
         else if (b >= 2 && b < 4) m_addr = 0;
         else if (b == 1) begin m_addr = 0; m_id = 1; end
      end
   endtask

   task automatic model_nib(input int rs, input int d);
      e_ev = 0;
      if (m_mode4 == 0) begin
         model_decode(rs, d * 16);
      end else if (m_have_hi == 0) begin
         m_have_hi = 1; m_hi_rs = rs; m_hi_d = d;
      end else begin
         m_have_hi = 0;
         model_decode(m_hi_rs, m_hi_d * 16 + d);
      end
   endtask

   task automatic check_state();
      chk("cur_addr", 32'(cur_addr), 32'(m_addr));
      chk("mode4", 32'(mode4), 32'(m_mode4));
      chk("disp_on", 32'(disp_on), 32'(m_disp));
      chk("sync_err", 32'(sync_err), 32'(m_sync));
      chk("cmd_byte", 32'(cmd_byte), 32'(m_cmd));
   endtask

   // One E pulse; strobes are expected exactly on the 3rd edge after E falls.
   task automatic send_nib(input logic rs, input logic [3:0] d);
      model_nib(int'(rs), int'(d));
      @(posedge CLK); #1;
      RS = rs; din = d; E = 1'b1;
      repeat (3) @(posedge CLK);
      #1 E = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("cmd_valid", 32'(cmd_valid), 32'(e_ev == 1));
      chk("wr_valid", 32'(wr_valid), 32'(e_ev == 2));
      if (e_ev == 2) begin
         chk("wr_addr", 32'(wr_addr), 32'(e_addr));
         chk("wr_data", 32'(wr_data), 32'(e_byte));
      end
      check_state();
      @(negedge CLK);
      chk("cmd_pulse_end", 32'(cmd_valid), 32'd0);
      chk("wr_pulse_end", 32'(wr_valid), 32'd0);
   endtask

   task automatic send_byte(input logic rs, input logic [7:0] b);
      send_nib(rs, b[7:4]);
      send_nib(rs, b[3:0]);
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RST = 1'b1; E = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      model_reset();
      @(negedge CLK);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      check_state();
   endtask

   task automatic init4();
      send_nib(1'b0, 4'h3);
      send_nib(1'b0, 4'h3);
      send_nib(1'b0, 4'h3);
      send_nib(1'b0, 4'h2);
   endtask

   initial begin
      logic       rs;
      logic [7:0] b;
      model_reset();
      do_reset();

      // Init sequence, then commands.
      init4();
      chk("init_mode4", 32'(mode4), 32'd1);
      send_byte(1'b0, 8'h0C);
      chk("disp_on_set", 32'(disp_on), 32'd1);
      send_byte(1'b0, 8'h01);

      // Data writes at 0x40.
      send_byte(1'b0, 8'hC0);
      send_byte(1'b1, 8'h54);
      send_byte(1'b1, 8'h68);
      chk("addr_after_th", 32'(cur_addr), 32'h42);

      // Wrap on increment, then decrement wrap.
      send_byte(1'b0, 8'hFF);
      send_byte(1'b1, 8'h41);
      chk("wrap_inc", 32'(cur_addr), 32'h00);
      send_byte(1'b0, 8'h04);
      send_byte(1'b1, 8'h42);
      chk("wrap_dec", 32'(cur_addr), 32'h7F);

      // Random bytes, some with RS differing between nibbles.
      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom_range(0, 1));
         b  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) begin
            send_nib(rs, b[7:4]);
            send_nib(~rs, b[3:0]);
         end else begin
            send_byte(rs, b);
         end
      end

      // Re-sync into 4-bit mode, then drop back with Function Set DL=1.
      init4();
      send_byte(1'b0, 8'h30);
      chk("resync_mode4", 32'(mode4), 32'd0);
      init4();

      // Reset between nibbles discards the held high nibble.
      send_nib(1'b0, 4'h4);
      do_reset();
      send_nib(1'b0, 4'h3);
      chk("post_rst_cmd", 32'(cmd_byte), 32'h30);

`ifdef LCD_RX_TIMEOUT_EN
      init4();
      send_nib(1'b1, 4'h7);
      repeat (20) @(posedge CLK);
      m_have_hi = 0;
      m_sync    = 1;
      @(negedge CLK);
      chk("timeout_sync_err", 32'(sync_err), 32'd1);
      send_nib(1'b1, 4'h4);
      send_nib(1'b1, 4'h1);
      chk("timeout_wr_data", 32'(wr_data), 32'h41);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Strobes must never coincide.
   always @(negedge CLK) begin
      if (!RST && cmd_valid && wr_valid) begin
         errors++;
         $error("FAIL both_strobes: got cmd_valid=1 wr_valid=1 expected not both");
      end
   end

endmodule
